alu_acc: RTL and testbench
==========================

ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of operands, result and accumulator (legal 2..32).
REQ-002 SHALL have parameter SAT, default 0: 0 = wrap-around arithmetic; 1 = unsigned saturating arithmetic.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  block enable; low freezes the block and blanks the display.
REQ-006 SHALL have port in_valid  input  1  operation request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-008 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ACC_ADD, 110 ACC_CLR, 111 PASS.
REQ-009 SHALL have port input_a  input  WIDTH  operand A, unsigned.
REQ-010 SHALL have port input_b  input  WIDTH  operand B, unsigned.
REQ-011 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port output_c  output  WIDTH  result; drives the LED bank.
REQ-014 SHALL have ports carry, ovf, zero  output  1 each  result flags, registered with output_c.

Function
REQ-015 SHALL drive in_ready = en & (!out_valid_q | out_ready); accept occurs when in_valid & in_ready at a rising edge.
REQ-016 SHALL register the result, flags and out_valid_q=1 on the edge of acceptance: latency exactly 1 cycle, throughput 1 op/cycle.
REQ-017 SHALL clear out_valid_q on an edge where out_valid_q & out_ready & en and no new accept occurs; accept and drain in the same cycle SHALL load the new result.
REQ-018 SHALL hold output_c, flags and out_valid_q stable while out_valid_q=1 and out_ready=0.
REQ-019 ADD: a+b; SUB: a-b; AND/OR/XOR: bitwise a,b; PASS: a; all truncated to WIDTH when SAT=0.
REQ-020 ACC_ADD: result = acc+a, and the internal WIDTH-bit accumulator SHALL be updated to that result.
REQ-021 ACC_CLR: result = 0 and accumulator cleared; operands ignored.
REQ-022 carry SHALL be unsigned carry-out for ADD/ACC_ADD, borrow (a<b) for SUB, 0 for all other ops.
REQ-023 ovf SHALL be two's-complement signed overflow for ADD/SUB/ACC_ADD, 0 for all other ops.
REQ-024 zero SHALL be 1 when the registered result equals 0, for every op.
REQ-025 With SAT=1, ADD/ACC_ADD with carry SHALL produce all-ones, SUB with borrow SHALL produce 0; the accumulator stores the saturated value; carry/ovf still reflect the unsaturated operation.
REQ-026 When en=0: in_ready=0, out_valid=0, output_c = all-ones, carry/ovf/zero = 0; internal registers and accumulator SHALL hold.
REQ-027 When en returns to 1, held result and out_valid_q SHALL reappear unchanged in the same cycle.
REQ-028 out_valid, output_c and flags SHALL be driven from registers gated only by en (no path from input_a/input_b/op to outputs).

Reset
REQ-029 rst_n low SHALL immediately, without a clock, set out_valid_q=0, result=0, carry=ovf=zero=0, accumulator=0.
REQ-030 Reset asserted mid-transaction SHALL discard the pending result; the first accept after rst_n rises SHALL behave as from power-up.

Verification (WIDTH=4 unless stated)
REQ-031 Reset, en=1, out_ready=1, ADD a=3 b=5 -> next cycle out_valid=1, output_c=8, carry=0, ovf=1, zero=0.
REQ-032 SUB a=2 b=5 -> SAT=0: output_c=0xD, carry=1; SAT=1: output_c=0x0, carry=1, zero=1.
REQ-033 out_ready=0 after ADD 1+1 -> output_c=2 held, in_ready=0, second request (XOR 0xF,0x3) not accepted; out_ready=1 -> same cycle accept, next cycle output_c=0xC.
REQ-034 ACC_ADD a=9 twice -> 9 then 2 with carry=1 (SAT=1: 9 then 0xF); ACC_CLR -> output_c=0, zero=1; ACC_ADD a=1 -> 1.
REQ-035 Result 0x6 valid, drop en -> output_c=0xF, out_valid=0, in_ready=0; raise en -> output_c=0x6, out_valid=1.
REQ-036 Pull rst_n low between clocks while result held and accumulator=7 -> outputs 0 immediately; after release ACC_ADD a=1 -> output_c=1.

Source files
------------

// File: rtl/alu_acc.sv
// Single-stage ALU with an internal accumulator and a valid/ready result register.
// The enable input freezes all state and blanks the LED-facing outputs to all-ones.
module alu_acc #(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_c,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_ACC_ADD = 3'b101;
    localparam logic [2:0] OP_ACC_CLR = 3'b110;
    localparam logic [2:0] OP_PASS    = 3'b111;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] acc_r;

    logic             accept_s;
    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;
    logic             acc_load_s;

    assign accept_s = in_valid & in_ready;

    // Datapath: one adder shared by ADD and ACC_ADD, a subtractor for SUB.
    always_comb begin
        add_x_s    = input_a;
        add_y_s    = input_b;
        res_s      = ALL_ZERO;
        carry_s    = 1'b0;
        ovf_s      = 1'b0;
        acc_load_s = 1'b0;
        if (op == OP_ACC_ADD) begin
            add_x_s = acc_r;
            add_y_s = input_a;
        end else begin
            add_x_s = input_a;
            add_y_s = input_b;
        end
        sum_s  = {1'b0, add_x_s} + {1'b0, add_y_s};
        diff_s = {1'b0, input_a} - {1'b0, input_b};
        case (op)
            OP_ADD, OP_ACC_ADD: begin
                carry_s    = sum_s[WIDTH];
                ovf_s      = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                             (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
                acc_load_s = (op == OP_ACC_ADD);
                if (SAT && sum_s[WIDTH]) begin
                    res_s = ALL_ONES;
                end else begin
                    res_s = sum_s[WIDTH-1:0];
                end
            end
            OP_SUB: begin
                carry_s = diff_s[WIDTH];
                ovf_s   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (diff_s[WIDTH-1] != input_a[WIDTH-1]);
                if (SAT && diff_s[WIDTH]) begin
                    res_s = ALL_ZERO;
                end else begin
                    res_s = diff_s[WIDTH-1:0];
                end
            end
            OP_AND:     res_s = input_a & input_b;
            OP_OR:      res_s = input_a | input_b;
            OP_XOR:     res_s = input_a ^ input_b;
            OP_ACC_CLR: begin
                res_s      = ALL_ZERO;
                acc_load_s = 1'b1;
            end
            OP_PASS:    res_s = input_a;
            default:    res_s = ALL_ZERO;
        endcase
    end

    // Result register, flags, valid bit and accumulator; all frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= ALL_ZERO;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            acc_r       <= ALL_ZERO;
        end else if (en) begin
            if (accept_s) begin
                result_r    <= res_s;
                carry_r     <= carry_s;
                ovf_r       <= ovf_s;
                zero_r      <= (res_s == ALL_ZERO);
                out_valid_r <= 1'b1;
                if (acc_load_s) begin
                    acc_r <= res_s;
                end
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Outputs come straight from registers, only masked by the enable.
    assign in_ready  = en & (~out_valid_r | out_ready);
    assign out_valid = en & out_valid_r;
    assign output_c  = en ? result_r : ALL_ONES;
    assign carry     = en & carry_r;
    assign ovf       = en & ovf_r;
    assign zero      = en & zero_r;

endmodule

// File: tb/tb_alu_acc.sv
// Scoreboard bench for alu_acc: a wrap-around and a saturating instance share one
// stimulus stream; an arithmetic reference model predicts every accepted result.
module tb_alu_acc;

    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct {
        int res;
        int c;
        int v;
        int z;
        int acc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en;
    logic in_valid;
    logic [2:0] op;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic out_ready;

    logic in_ready0, out_valid0, carry0, ovf0, zero0;
    logic in_ready1, out_valid1, carry1, ovf1, zero1;
    logic [W-1:0] output_c0, output_c1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int acc0 = 0;
    int acc1 = 0;
    bit mvalid = 1'b0;

    alu_acc #(.WIDTH(W), .SAT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .input_a(input_a), .input_b(input_b), .out_valid(out_valid0),
        .out_ready(out_ready), .output_c(output_c0), .carry(carry0), .ovf(ovf0), .zero(zero0)
    );

    alu_acc #(.WIDTH(W), .SAT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .input_a(input_a), .input_b(input_b), .out_valid(out_valid1),
        .out_ready(out_ready), .output_c(output_c1), .carry(carry1), .ovf(ovf1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn(int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed interpretations.
    function automatic exp_t model(int o, int a, int b, int acc, bit sat);
        exp_t e;
        int r;
        int s;
        e.c = 0;
        e.v = 0;
        e.acc = acc;
        r = 0;
        case (o)
            0, 5: begin
                int x;
                int y;
                x = (o == 5) ? acc : a;
                y = (o == 5) ? a : b;
                r = x + y;
                s = sgn(x) + sgn(y);
                e.c = (r >= M) ? 1 : 0;
                e.v = (s >= M / 2 || s < -M / 2) ? 1 : 0;
                if (sat && e.c == 1) r = M - 1;
            end
            1: begin
                r = a - b;
                s = sgn(a) - sgn(b);
                e.c = (a < b) ? 1 : 0;
                e.v = (s >= M / 2 || s < -M / 2) ? 1 : 0;
                if (sat && e.c == 1) r = 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            6: r = 0;
            default: r = a;
        endcase
        e.res = ((r % M) + M) % M;
        e.z = (e.res == 0) ? 1 : 0;
        if (o == 5 || o == 6) e.acc = e.res;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(string nm, exp_t e, logic [W-1:0] c, logic cy, logic v, logic z);
        chk({nm, ".output_c"}, 32'(c), e.res);
        chk({nm, ".carry"}, 32'(cy), e.c);
        chk({nm, ".ovf"}, 32'(v), e.v);
        chk({nm, ".zero"}, 32'(z), e.z);
    endtask

    // Monitor: whenever a result is presented and consumed, compare it with the queue head.
    always @(negedge clk) begin
        #2;
        if (rst_n && en && out_ready) begin
            if (out_valid0) begin
                if (q0.size() == 0) chk("unexpected_result0", 32'd1, 32'd0);
                else check_out("wrap", q0.pop_front(), output_c0, carry0, ovf0, zero0);
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("unexpected_result1", 32'd1, 32'd0);
                else check_out("sat", q1.pop_front(), output_c1, carry1, ovf1, zero1);
            end
        end
    end

    task automatic cyc(bit e, bit v, int o, int a, int b, bit r);
        bit rdy;
        exp_t x0;
        exp_t x1;
        @(negedge clk);
        en = e;
        in_valid = v;
        op = 3'(o);
        input_a = W'(a);
        input_b = W'(b);
        out_ready = r;
        #1;
        rdy = e && (!mvalid || r);
        chk("in_ready0", 32'(in_ready0), 32'(rdy));
        chk("in_ready1", 32'(in_ready1), 32'(rdy));
        chk("out_valid0", 32'(out_valid0), 32'(e && mvalid));
        chk("out_valid1", 32'(out_valid1), 32'(e && mvalid));
        if (!e) begin
            chk("blank_c0", 32'(output_c0), M - 1);
            chk("blank_c1", 32'(output_c1), M - 1);
            chk("blank_flags", {29'd0, carry0 | carry1, ovf0 | ovf1, zero0 | zero1}, 32'd0);
        end else if (mvalid) begin
            if (q0.size() == 0 || q1.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else begin
                chk("held_c0", 32'(output_c0), q0[0].res);
                chk("held_c1", 32'(output_c1), q1[0].res);
            end
        end
        if (v && rdy) begin
            x0 = model(o, a, b, acc0, 1'b0);
            x1 = model(o, a, b, acc1, 1'b1);
            acc0 = x0.acc;
            acc1 = x1.acc;
            q0.push_back(x0);
            q1.push_back(x1);
            mvalid = 1'b1;
        end else if (e && r) begin
            mvalid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        in_valid = 1'b0;
        op = 3'd0;
        input_a = '0;
        input_b = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c0", 32'(output_c0), 32'd0);
        chk("rst_c1", 32'(output_c1), 32'd0);
        chk("rst_valid", 32'(out_valid0 | out_valid1), 32'd0);
        chk("rst_flags", {29'd0, carry0 | carry1, ovf0 | ovf1, zero0 | zero1}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // ADD 3+5: fixed expectation independent of the model
        cyc(1, 1, 0, 3, 5, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("add35_c", 32'(output_c0), 32'd8);
        chk("add35_flags", {29'd0, carry0, ovf0, zero0}, 32'b010);
        cyc(1, 1, 1, 2, 5, 1);                // SUB with borrow
        cyc(1, 1, 0, 1, 1, 0);                // ADD 1+1 then stall
        cyc(1, 1, 4, 15, 3, 0);
        cyc(1, 1, 4, 15, 3, 0);
        cyc(1, 1, 4, 15, 3, 1);               // drain and accept together
        cyc(1, 1, 5, 9, 0, 1);                // accumulator sequence
        cyc(1, 1, 5, 9, 0, 1);
        cyc(1, 1, 6, 5, 5, 1);
        cyc(1, 1, 5, 1, 0, 1);
        cyc(1, 1, 7, 6, 0, 0);                // PASS 6 held, then enable drop
        cyc(0, 1, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 1);
        cyc(1, 1, 5, 7, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Asynchronous reset between clocks while a result is held
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_c0", 32'(output_c0), 32'd0);
        chk("arst_c1", 32'(output_c1), 32'd0);
        chk("arst_valid", 32'(out_valid0 | out_valid1), 32'd0);
        chk("arst_flags", {29'd0, carry0 | carry1, ovf0 | ovf1, zero0 | zero1}, 32'd0);
        q0.delete();
        q1.delete();
        acc0 = 0;
        acc1 = 0;
        mvalid = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 1, 5, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                $urandom_range(0, M - 1), $urandom_range(0, M - 1), $urandom_range(0, 9) < 7);
        end

        repeat (3) cyc(1, 0, 0, 0, 0, 1);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
